// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises ps2_clk/ps2_data, deframes and checks
// 11-bit frames, and queues good scan codes in a show-ahead FIFO for the display stage.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT     = 4'd10;

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall;
    logic          bit_sample;
    logic          frame_ok;

    logic [3:0]    bit_cnt_q,  bit_cnt_d;
    logic [9:0]    shift_q,    shift_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic [7:0]    byte_q,     byte_d;
    logic          push_q,     push_d;
    logic          err_q,      err_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          pop, full, wr_en;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_sample = dat_sync_q[1];
    // shift_q holds start in [0], D0..D7 in [8:1], parity in [9]; stop is the live sample.
    assign frame_ok   = ~shift_q[0] & bit_sample & (^shift_q[9:1]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        byte_d    = byte_q;
        push_d    = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (frame_ok) begin
                    push_d = 1'b1;
                    byte_d = shift_q[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_sample, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == TIMEOUT_LAST) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                tmo_d     = '0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            byte_q    <= '0;
            push_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            byte_q    <= byte_d;
            push_q    <= push_d;
            err_q     <= err_d;
        end
    end

    assign ready = (count_q != '0);
    assign full  = (count_q == FULL_COUNT);
    assign pop   = ~nextdata_n & ready;
    assign wr_en = push_q & (~full | pop);

    // NOTE: storage is reset so data reads 0x00 after reset; it costs a reset net per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= byte_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_q && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign data      = mem_q[rd_ptr_q];
    assign overflow  = ovf_q;
    assign frame_err = err_q;

endmodule
